// File: rtl/sspim_pkg.sv
// Shared types and constants for the single-SPI master transceiver.
package sspim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } sspim_xcvr_st_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] SSPIM_MODE0 = 2'b00;
  localparam logic [1:0] SSPIM_MODE1 = 2'b01;
  localparam logic [1:0] SSPIM_MODE2 = 2'b10;
  localparam logic [1:0] SSPIM_MODE3 = 2'b11;

endpackage

// File: rtl/sspim_xcvr_if.sv
// Control/status and pad bundle of the SPI master transceiver.
// master: register/control block plus pad side; slave: the transceiver.
interface sspim_xcvr_if #(
  parameter int DW   = 32,
  parameter int NCS  = 4,
  parameter int DIVW = 8
);
  localparam int LW = $clog2(DW);
  localparam int SW = (NCS > 1) ? $clog2(NCS) : 1;

  logic            cfg_cpol;
  logic            cfg_cpha;
  logic            cfg_lsb_first;
  logic [LW-1:0]   cfg_bit_len;
  logic [DIVW-1:0] cfg_clk_div;
  logic [SW-1:0]   cfg_tgt_sel;
  logic            cfg_cs_hold;
  logic            start;
  logic [DW-1:0]   tx_data;
  logic            busy;
  logic            done;
  logic [DW-1:0]   rx_data;
  logic            sck;
  logic            so;
  logic            si;
  logic [NCS-1:0]  cs_n;

  modport master (
    output cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_bit_len, cfg_clk_div,
           cfg_tgt_sel, cfg_cs_hold, start, tx_data, si,
    input  busy, done, rx_data, sck, so, cs_n
  );

  modport slave (
    input  cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_bit_len, cfg_clk_div,
           cfg_tgt_sel, cfg_cs_hold, start, tx_data, si,
    output busy, done, rx_data, sck, so, cs_n
  );

endinterface

// File: rtl/sspim_clkgen.sv
// SCK half-period timer: one-cycle tick after every D = i_div+1 enabled cycles.
module sspim_clkgen #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_en,
  input  logic            i_restart,
  input  logic [DIVW-1:0] i_div,
  output logic            o_tick
);

  logic [DIVW-1:0] r_cnt;

  assign o_tick = i_en && !i_restart && (r_cnt == i_div);

  // Count up to i_div and wrap; held at zero when disabled so every
  // state entry starts a full half-period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    r_cnt <= '0;
    else if (!i_en || i_restart)     r_cnt <= '0;
    else if (o_tick)                 r_cnt <= '0;
    else                             r_cnt <= r_cnt + DIVW'(1);
  end

endmodule

// File: rtl/sspim_xcvr.sv
// Single-SPI master transceiver: runs one frame per accepted start with
// programmable mode, bit order, length, SCK divider and chip select.
module sspim_xcvr
  import sspim_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NCS  = 4,
  parameter int DIVW = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  sspim_xcvr_if.slave  bus
);

  localparam int LW = $clog2(DW);
  localparam int EW = LW + 1;
  localparam int SW = (NCS > 1) ? $clog2(NCS) : 1;

  sspim_xcvr_st_e  r_st;
  logic            r_cpha;
  logic            r_lsb;
  logic [LW-1:0]   r_len;
  logic [DIVW-1:0] r_div;
  logic            r_hold;
  logic [DW-1:0]   r_tx;
  logic [DW-1:0]   r_rx;
  logic [EW-1:0]   r_edge;
  logic            r_sck;
  logic            r_so;
  logic            r_busy;
  logic            r_done;
  logic [NCS-1:0]  r_cs_n;

  logic            w_tick;
  logic            w_accept;
  logic [EW-1:0]   w_last;
  logic [EW-1:0]   w_eidx;
  logic            w_edge;
  logic            w_lead;
  logic            w_smp;
  logic [LW-1:0]   w_k;
  logic [LW-1:0]   w_pos;
  logic [LW-1:0]   w_pos_nx;
  logic [LW-1:0]   w_pos0;
  logic [NCS-1:0]  w_cs_dec;

  sspim_clkgen #(.DIVW(DIVW)) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (r_st != IDLE),
    .i_restart (w_accept),
    .i_div     (r_div),
    .o_tick    (w_tick)
  );

  assign w_accept = (r_st == IDLE) && bus.start;

  // Toggle index of the last edge in the frame is 2n-1 = {n-1, 1}.
  assign w_last = {r_len, 1'b1};

  // Edge 0 fires on the SETUP tick; later edges on XFER ticks until the last.
  assign w_eidx = (r_st == SETUP) ? '0 : r_edge + EW'(1);
  assign w_edge = w_tick && ((r_st == SETUP) || ((r_st == XFER) && (r_edge != w_last)));
  assign w_lead = !w_eidx[0];
  assign w_k    = w_eidx[EW-1:1];
  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
  assign w_smp  = w_edge && (w_lead != r_cpha);

  // Bit position of data bit k (and k+1) in transfer order.
  assign w_pos    = r_lsb ? w_k : r_len - w_k;
  assign w_pos_nx = r_lsb ? w_k + LW'(1) : r_len - w_k - LW'(1);
  assign w_pos0   = bus.cfg_lsb_first ? '0 : bus.cfg_bit_len;

  // One-hot active-low select; out-of-range targets select nothing.
  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NCS; i++)
      if (bus.cfg_tgt_sel == SW'(i)) w_cs_dec[i] = 1'b0;
  end

  // Frame sequencer with registered outputs and per-edge shift/sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st   <= IDLE;
      r_cpha <= 1'b0;
      r_lsb  <= 1'b0;
      r_len  <= '0;
      r_div  <= '0;
      r_hold <= 1'b0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_edge <= '0;
      r_sck  <= 1'b0;
      r_so   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cs_n <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_st)
        IDLE: begin
          r_sck <= bus.cfg_cpol;
          if (bus.start) begin
            r_cpha <= bus.cfg_cpha;
            r_lsb  <= bus.cfg_lsb_first;
            r_len  <= bus.cfg_bit_len;
            r_div  <= bus.cfg_clk_div;
            r_hold <= bus.cfg_cs_hold;
            r_tx   <= bus.tx_data;
            r_rx   <= '0;
            r_busy <= 1'b1;
            r_cs_n <= w_cs_dec;
            r_st   <= SETUP;
            if (!bus.cfg_cpha) r_so <= bus.tx_data[w_pos0];
          end else if (!bus.cfg_cs_hold) begin
            r_cs_n <= '1;
          end
        end
        SETUP: begin
          if (w_tick) begin
            r_edge <= '0;
            r_st   <= XFER;
          end
        end
        XFER: begin
          if (w_tick) begin
            if (r_edge == w_last) r_st   <= HOLD;
            else                  r_edge <= w_eidx;
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_st   <= IDLE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            if (!r_hold) r_cs_n <= '1;
          end
        end
        default: r_st <= IDLE;
      endcase

      if (w_edge) begin
        r_sck <= ~r_sck;
        if (w_smp)                r_rx[w_pos] <= bus.si;
        else if (r_cpha)          r_so <= r_tx[w_pos];
        else if (w_k != r_len)    r_so <= r_tx[w_pos_nx];
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx;
  assign bus.sck     = r_sck;
  assign bus.so      = r_so;
  assign bus.cs_n    = r_cs_n;

endmodule

// File: tb/tb_sspim_xcvr.sv
// Self-checking bench for sspim_xcvr with an SPI slave model and waveform monitor.
module tb_sspim_xcvr;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sspim_xcvr_if #(.DW(32), .NCS(4), .DIVW(8)) bus ();
  sspim_xcvr #(.DW(32), .NCS(4), .DIVW(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, done_cyc = 0, done_cnt = 0, ecnt = 0, cs_bad = 0;
  int tog_q[$];
  logic so_q[$];
  logic p_sck = 1'b0, p_busy = 1'b0, si_drv = 1'b0, loop = 1'b0, cs_watch = 1'b0;
  logic [3:0] cs_exp = 4'hF;
  logic [31:0] slv_word = '0;
  int slv_n = 8;
  logic slv_lsb = 1'b0, slv_cpha = 1'b0;
  logic dn_sck, dn_busy, b1_busy;
  logic [3:0] dn_cs, b1_cs;
  logic [31:0] dn_rx;

  assign bus.si = loop ? bus.so : si_drv;

  // Slave bit j in its transmit order.
  function automatic logic sbit(input int j);
    return slv_lsb ? slv_word[j] : slv_word[slv_n-1-j];
  endfunction

  function automatic logic [31:0] msk(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // Word the slave received on so, placed back by bit order.
  function automatic logic [31:0] obs_word();
    logic [31:0] w = '0;
    for (int j = 0; j < slv_n && j < so_q.size(); j++)
      if (slv_lsb) w[j] = so_q[j];
      else         w[slv_n-1-j] = so_q[j];
    return w;
  endfunction

  // Number of sck toggles not on the expected cycle t0+1+D+i*D.
  function automatic int tog_err(input int d);
    int e = 0;
    for (int i = 0; i < tog_q.size(); i++)
      if (tog_q[i] != t0 + 1 + d + i*d) e++;
    return e;
  endfunction

  // Cycle counter, sck edge log, slave behaviour and done/CS watch.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.busy && !p_busy) begin
      ecnt = 0;
      if (!slv_cpha) si_drv = sbit(0);
    end
    if (bus.busy && p_busy && (bus.sck !== p_sck)) begin
      tog_q.push_back(cyc);
      if ((ecnt % 2) == int'(slv_cpha)) so_q.push_back(bus.so);
      if (!slv_cpha && (ecnt % 2) == 1 && (ecnt+1)/2 < slv_n) si_drv = sbit((ecnt+1)/2);
      if (slv_cpha && (ecnt % 2) == 0) si_drv = sbit(ecnt/2);
      ecnt++;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cs_watch && bus.cs_n !== cs_exp) cs_bad++;
    p_sck  = bus.sck;
    p_busy = bus.busy;
  end

  // Runs one frame from a negedge; returns at the negedge of the done cycle,
  // on a bounded timeout, or after `abort` sck toggles when abort > 0.
  task automatic do_frame(input logic cpol, cpha, lsb, input int n, d, sel,
                          input logic hold, input logic [31:0] tx, sw,
                          input int chaos, abort);
    int budget;
    bus.cfg_cpol = cpol;  bus.cfg_cpha = cpha;  bus.cfg_lsb_first = lsb;
    bus.cfg_bit_len = 5'(n-1);  bus.cfg_clk_div = 8'(d-1);
    bus.cfg_tgt_sel = 2'(sel);  bus.cfg_cs_hold = hold;  bus.tx_data = tx;
    slv_word = sw;  slv_n = n;  slv_lsb = lsb;  slv_cpha = cpha;
    tog_q.delete();  so_q.delete();  done_cnt = 0;
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    b1_busy = bus.busy;
    b1_cs   = bus.cs_n;
    if (chaos != 0) bus.start = 1'b1;
    budget = 2*(1 + (2*n+2)*d) + 10;
    while (done_cnt == 0 && cyc < t0 + budget) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (chaos != 0 && cyc == t0 + 1 + d + n*d) begin
        bus.start = 1'b1;
        bus.cfg_cpol = ~cpol;  bus.cfg_cpha = ~cpha;  bus.cfg_lsb_first = ~lsb;
        bus.cfg_bit_len = 5'($urandom);  bus.cfg_clk_div = 8'($urandom);
        bus.cfg_tgt_sel = 2'($urandom);  bus.tx_data = $urandom;
      end
      if (abort > 0 && tog_q.size() >= abort) return;
    end
    dn_sck = bus.sck;  dn_busy = bus.busy;  dn_cs = bus.cs_n;  dn_rx = bus.rx_data;
  endtask

  task automatic test_reset();
    bus.cfg_cpol = 0; bus.cfg_cpha = 0; bus.cfg_lsb_first = 0; bus.cfg_bit_len = '0;
    bus.cfg_clk_div = '0; bus.cfg_tgt_sel = '0; bus.cfg_cs_hold = 0; bus.start = 0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.sck, bus.so, bus.busy, bus.done} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl got %b exp 0000", {bus.sck, bus.so, bus.busy, bus.done});
    end
    checks++;
    if ({bus.cs_n, bus.rx_data} !== {4'hF, 32'h0}) begin
      errors++; $display("FAIL reset_cs_rx got %h/%h exp f/0", bus.cs_n, bus.rx_data);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_loop();
    loop = 1'b1;
    do_frame(0, 0, 0, 8, 1, 0, 0, 32'hA5, 32'h0, 0, 0);
    loop = 1'b0;
    checks++; if (b1_busy !== 1'b1 || b1_cs !== 4'b1110) begin
      errors++; $display("FAIL m0_start busy %b cs %b exp 1 1110", b1_busy, b1_cs); end
    checks++; if (done_cnt !== 1 || done_cyc !== t0 + 19) begin
      errors++; $display("FAIL m0_done cnt %0d at %0d exp 1 at %0d", done_cnt, done_cyc, t0+19); end
    checks++; if (tog_q.size() !== 16 || tog_err(1) !== 0) begin
      errors++; $display("FAIL m0_sck toggles %0d bad %0d exp 16 0", tog_q.size(), tog_err(1)); end
    checks++; if (dn_rx !== 32'h0000_00A5) begin
      errors++; $display("FAIL m0_rx got %h exp 000000a5", dn_rx); end
    checks++; if (obs_word() !== 32'hA5) begin
      errors++; $display("FAIL m0_so got %h exp a5", obs_word()); end
    checks++; if (dn_sck !== 1'b0 || dn_busy !== 1'b0) begin
      errors++; $display("FAIL m0_idle sck %b busy %b exp 0 0", dn_sck, dn_busy); end
  endtask

  task automatic test_mode3_lsb();
    do_frame(1, 1, 1, 16, 4, 1, 0, 32'h1234, 32'hBEEF, 0, 0);
    checks++; if (b1_cs !== 4'b1101) begin
      errors++; $display("FAIL m3_cs got %b exp 1101", b1_cs); end
    checks++; if (done_cnt !== 1 || done_cyc !== t0 + 137) begin
      errors++; $display("FAIL m3_done cnt %0d at %0d exp 1 at %0d", done_cnt, done_cyc, t0+137); end
    checks++; if (tog_q.size() !== 32 || tog_err(4) !== 0) begin
      errors++; $display("FAIL m3_sck toggles %0d bad %0d exp 32 0", tog_q.size(), tog_err(4)); end
    checks++; if (dn_rx !== 32'h0000_BEEF) begin
      errors++; $display("FAIL m3_rx got %h exp 0000beef", dn_rx); end
    checks++; if (obs_word() !== 32'h1234) begin
      errors++; $display("FAIL m3_so got %h exp 1234", obs_word()); end
    checks++; if (dn_sck !== 1'b1) begin
      errors++; $display("FAIL m3_idle sck %b exp 1", dn_sck); end
  endtask

  task automatic test_cs_hold();
    logic [31:0] sw1, sw2;
    int t1;
    sw1 = $urandom;  sw2 = $urandom;
    cs_exp = 4'b1011;  cs_bad = 0;  cs_watch = 1'b1;
    do_frame(0, 0, 0, 8, 2, 2, 1, $urandom, sw1, 0, 0);
    checks++; if (done_cnt !== 1 || dn_rx !== (sw1 & 32'hFF)) begin
      errors++; $display("FAIL hold_f1 done %0d rx %h exp 1 %h", done_cnt, dn_rx, sw1 & 32'hFF); end
    t1 = done_cyc;
    do_frame(0, 0, 0, 8, 2, 2, 1, $urandom, sw2, 0, 0);
    cs_watch = 1'b0;
    checks++; if (t0 !== t1 || done_cyc !== t1 + 37 || dn_rx !== (sw2 & 32'hFF)) begin
      errors++; $display("FAIL hold_b2b done %0d rx %h exp %0d %h", done_cyc, dn_rx, t1+37, sw2 & 32'hFF); end
    checks++; if (cs_bad !== 0 || dn_cs !== 4'b1011) begin
      errors++; $display("FAIL hold_cs bad cycles %0d done cs %b exp 0 1011", cs_bad, dn_cs); end
    bus.cfg_cs_hold = 1'b0;
    @(negedge clk);
    checks++; if (bus.cs_n !== 4'hF) begin
      errors++; $display("FAIL hold_release cs %b exp 1111", bus.cs_n); end
  endtask

  task automatic test_ignore_start();
    logic [31:0] tx, sw;
    tx = $urandom;  sw = $urandom;
    do_frame(1, 0, 0, 12, 3, 3, 0, tx, sw, 1, 0);
    checks++; if (b1_cs !== 4'b0111 || done_cyc !== t0 + 1 + 26*3) begin
      errors++; $display("FAIL ign_frame cs %b done %0d exp 0111 %0d", b1_cs, done_cyc, t0+79); end
    checks++; if (tog_q.size() !== 24 || tog_err(3) !== 0) begin
      errors++; $display("FAIL ign_sck toggles %0d bad %0d exp 24 0", tog_q.size(), tog_err(3)); end
    checks++; if (dn_rx !== (sw & msk(12)) || obs_word() !== (tx & msk(12))) begin
      errors++; $display("FAIL ign_data rx %h so %h exp %h %h", dn_rx, obs_word(), sw & msk(12), tx & msk(12)); end
    repeat (40) @(negedge clk);
    checks++; if (done_cnt !== 1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL ign_once dones %0d busy %b exp 1 0", done_cnt, bus.busy); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] tx, sw;
    do_frame(0, 1, 0, 32, 2, 0, 0, $urandom, $urandom, 0, 5);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.cs_n, bus.sck, bus.busy, bus.done, bus.rx_data} !== {4'hF, 3'b000, 32'h0}) begin
      errors++; $display("FAIL rst_mid cs %b sck %b busy %b rx %h exp 1111 0 0 0",
                         bus.cs_n, bus.sck, bus.busy, bus.rx_data); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== 0) begin
      errors++; $display("FAIL rst_nodone dones %0d exp 0", done_cnt); end
    tx = $urandom;  sw = $urandom;
    do_frame(0, 1, 0, 32, 2, 0, 0, tx, sw, 0, 0);
    checks++; if (done_cnt !== 1 || done_cyc !== t0 + 1 + 66*2) begin
      errors++; $display("FAIL rst_fresh_done cnt %0d at %0d exp 1 %0d", done_cnt, done_cyc, t0+133); end
    checks++; if (dn_rx !== sw || obs_word() !== tx) begin
      errors++; $display("FAIL rst_fresh_data rx %h so %h exp %h %h", dn_rx, obs_word(), sw, tx); end
  endtask

  task automatic test_long_div();
    int nv[2] = '{1, 32};
    for (int k = 0; k < 2; k++) begin
      logic [31:0] tx, sw;
      int n;
      n = nv[k];  tx = $urandom;  sw = $urandom;
      do_frame(1'($urandom), 1'($urandom), 1'($urandom), n, 256, 1, 0, tx, sw, 0, 0);
      checks++; if (tog_q.size() !== 2*n || tog_err(256) !== 0) begin
        errors++; $display("FAIL div256_n%0d toggles %0d bad %0d exp %0d 0", n, tog_q.size(), tog_err(256), 2*n); end
      checks++; if (done_cyc !== t0 + 1 + (2*n+2)*256 || dn_rx !== (sw & msk(n))) begin
        errors++; $display("FAIL div256_n%0d done %0d rx %h exp %0d %h", n, done_cyc, dn_rx,
                           t0+1+(2*n+2)*256, sw & msk(n)); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [31:0] tx, sw;
      logic [3:0] ce;
      int n, d, sel;
      logic cpol, cpha, lsb;
      n = $urandom_range(1, 32);  d = $urandom_range(1, 4);  sel = $urandom_range(0, 3);
      cpol = 1'($urandom);  cpha = 1'($urandom);  lsb = 1'($urandom);
      tx = $urandom;  sw = $urandom;
      ce = 4'hF;  ce[sel] = 1'b0;
      do_frame(cpol, cpha, lsb, n, d, sel, 0, tx, sw, 0, 0);
      checks++; if (b1_cs !== ce || done_cnt !== 1 || done_cyc !== t0 + 1 + (2*n+2)*d) begin
        errors++; $display("FAIL rnd%0d_frame cs %b done %0d exp %b %0d", it, b1_cs, done_cyc, ce, t0+1+(2*n+2)*d); end
      checks++; if (tog_q.size() !== 2*n || tog_err(d) !== 0 || dn_sck !== cpol) begin
        errors++; $display("FAIL rnd%0d_sck toggles %0d bad %0d idle %b exp %0d 0 %b",
                           it, tog_q.size(), tog_err(d), dn_sck, 2*n, cpol); end
      checks++; if (dn_rx !== (sw & msk(n)) || obs_word() !== (tx & msk(n))) begin
        errors++; $display("FAIL rnd%0d_data rx %h so %h exp %h %h", it, dn_rx, obs_word(), sw & msk(n), tx & msk(n)); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_loop();
    test_mode3_lsb();
    test_cs_hold();
    test_ignore_start();
    test_reset_midframe();
    test_long_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
